// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with bounded data-memory handshake.
// Define CTRL_TRAP_EN to send illegal opcodes and MEM timeouts to a sticky HALT state.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       dmem_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic       jump,
  output logic       beq,
  output logic       bne,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic       dmem_req,
  output logic       instr_done,
  output logic       bus_err,
  output logic       halted,
  output logic [2:0] state
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5;
`ifdef CTRL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic [2:0] state_next;
  logic [3:0] op_q;
  logic [7:0] wait_cnt;
  logic is_ld, is_st, is_r, is_beq, is_bne, is_jmp, is_br, is_ill, held, act, time_out;
  assign is_ld    = op_q == 4'h0;
  assign is_st    = op_q == 4'h1;
  assign is_r     = op_q >= 4'h2 && op_q <= 4'h9;
  assign is_beq   = op_q == 4'hb;
  assign is_bne   = op_q == 4'hc;
  assign is_jmp   = op_q == 4'hd;
  assign is_br    = is_beq | is_bne | is_jmp;
  assign is_ill   = !(is_ld | is_st | is_r | is_br);
  assign held     = state == EXEC || state == MEM || state == WB;
  assign act      = !rst;
  // An ack arriving on the final allowed cycle wins over the timeout.
  assign time_out = state == MEM && !dmem_ack && wait_cnt == 8'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else state <= state_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q     <= 4'h0;
      wait_cnt <= 8'h0;
    end else begin
      if (state == DECODE) op_q <= opcode;
      wait_cnt <= (state == MEM && !dmem_ack) ? wait_cnt + 8'h1 : 8'h0;
    end
  always_comb begin
    state_next =
      (state == FETCH)  ? DECODE :
      (state == DECODE) ? EXEC :
      (state == EXEC)   ? ((is_ld | is_st) ? MEM : is_r ? WB : (is_ill && TRAP) ? HALT : FETCH) :
      (state == MEM)    ? (dmem_ack ? (is_ld ? WB : FETCH) : time_out ? (TRAP ? HALT : FETCH) : MEM) :
      (state == HALT)   ? HALT : FETCH;
  end
  always_comb begin
    ir_we      = act && state == FETCH;
    pc_we      = act && ((state == EXEC && (is_br || (is_ill && !TRAP))) ||
                         (state == MEM && ((dmem_ack && is_st) || (time_out && !TRAP))) ||
                         state == WB);
    jump       = act && state == EXEC && is_jmp;
    beq        = act && state == EXEC && is_beq;
    bne        = act && state == EXEC && is_bne;
    dmem_req   = act && state == MEM;
    mem_read   = act && state == MEM && is_ld;
    mem_write  = act && state == MEM && is_st;
    alu_src    = act && held && (is_ld | is_st);
    reg_dst    = act && held && is_r;
    mem_to_reg = act && state == WB && is_ld;
    reg_write  = act && state == WB;
    alu_op     = !(act && held) ? 2'b00 : (is_ld | is_st) ? 2'b10 : (is_beq | is_bne) ? 2'b01 : 2'b00;
    instr_done = pc_we;
    bus_err    = act && time_out;
`ifdef CTRL_TRAP_EN
    halted     = act && state == HALT;
`else
    halted     = 1'b0;
`endif
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction stream checked cycle-by-cycle against a per-instruction schedule model.
module tb_multicycle_ctrl;
  localparam int TO = 4;
`ifdef CTRL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 0, rst = 1, dmem_ack = 0;
  logic [3:0] opcode = 0;
  logic ir_we, pc_we, jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
  logic [1:0] alu_op;
  logic dmem_req, instr_done, bus_err, halted;
  logic [2:0] state;
  logic [19:0] got;
  int checks = 0, errors = 0;
  bit trapped;
  typedef struct packed { logic ack; logic [19:0] v; } cyc_t;
  cyc_t q[$];

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we),
    .jump(jump), .beq(beq), .bne(bne), .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_op(alu_op),
    .dmem_req(dmem_req), .instr_done(instr_done), .bus_err(bus_err), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;
  assign got = {ir_we, pc_we, jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg,
                reg_write, alu_op, dmem_req, instr_done, bus_err, halted, state};

  task automatic check(string tag, logic [19:0] obs, logic [19:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] pk(int st, bit irw, bit pcw, bit j, bit bq, bit bn, bit mr, bit mw,
                                     bit as, bit rd, bit mtr, bit rw, logic [1:0] ao, bit req, bit be, bit h);
    return {irw, pcw, j, bq, bn, mr, mw, as, rd, mtr, rw, ao, req, pcw, be, h, 3'(st)};
  endfunction

  function automatic cyc_t c(logic [19:0] v, logic ack = logic'($urandom_range(0, 1)));
    return {ack, v};
  endfunction

  // Expected cycles of one instruction; k = MEM cycles before ack (k >= TO means no ack).
  task automatic plan(logic [3:0] o, int k);
    bit ld = o == 0, st = o == 1, ls = ld | st, r = o >= 2 && o <= 9;
    bit bq = o == 11, bn = o == 12, jp = o == 13, br = bq | bn | jp, ill = !(ls | r | br);
    logic [1:0] ao = ls ? 2'b10 : (bq | bn) ? 2'b01 : 2'b00;
    bit be = 0, halt = 0;
    q.delete();
    q.push_back(c(pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    q.push_back(c(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    q.push_back(c(pk(2, 0, br | (ill & !TRAP), jp, bq, bn, 0, 0, ls, r, 0, 0, ao, 0, 0, 0)));
    halt = ill & TRAP;
    if (ls) for (int i = 1; i <= TO; i++) begin
      bit a = i == k + 1;
      be = !a && i == TO;
      q.push_back(c(pk(3, 0, (a & st) | (be & !TRAP), 0, 0, 0, ld, st, 1, 0, 0, 0, 2'b10, 1, be, 0), a));
      if (a || be) break;
    end
    halt |= be & TRAP;
    if ((ld && !be) || r) q.push_back(c(pk(4, 0, 1, 0, 0, 0, 0, 0, ls, r, ld, 1, ao, 0, 0, 0)));
    if (halt) repeat (3) q.push_back(c(pk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    trapped = halt;
  endtask

  // Called just after a negedge; checks up to lim cycles, ends just after a later negedge.
  task automatic run(logic [3:0] o, int k, int lim = 1000);
    plan(o, k);
    for (int i = 0; i < q.size() && i < lim; i++) begin
      opcode = o;
      dmem_ack = q[i].ack;
      #1 check($sformatf("op%0h_k%0d_c%0d", o, k, i), got, q[i].v);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(string tag);
    rst = 1;
    dmem_ack = 1;
    #1 check({tag, "_async"}, got, 20'h0);
    @(negedge clk);
    check({tag, "_held"}, got, 20'h0);
    rst = 0;
    trapped = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset("por");
    run(4'h2, 0);
    run(4'h0, 3);
    run(4'hb, 0);
    run(4'h1, 10);
    if (trapped) do_reset("trap_st");
    run(4'he, 0);
    if (trapped) do_reset("trap_ill");
    run(4'h0, 10, 5);
    do_reset("mid_mem");
    run(4'hc, 0);
    run(4'h1, 0);
    run(4'hd, 0);
    for (int n = 0; n < 60; n++) begin
      run(4'($urandom_range(0, 15)), int'($urandom_range(0, 5)));
      if (trapped) do_reset("trap_rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the 16-bit RISC datapath. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath control strobe, plus a PC write enable and an instruction-register load. It also handles a variable-latency data-memory handshake and bounds it with a timeout. It sits between the datapath's opcode output and its control inputs, replacing the single-cycle control unit.

## Interface
- MEM_TIMEOUT, default 16: maximum MEM-state cycles without `dmem_ack` before abort (range 1–255).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  4  instruction[15:12] from the datapath; valid from DECODE onward.
- `dmem_ack`  in  1  data memory completed the access this cycle.
- `ir_we`  out  1  load the instruction register.
- `pc_we`  out  1  load `pc_next` into the PC.
- `jump`, `beq`, `bne`  out  1 each  PC-select controls.
- `mem_read`, `mem_write`  out  1 each  data memory strobes.
- `alu_src`, `reg_dst`, `mem_to_reg`, `reg_write`  out  1 each  datapath muxes and register write.
- `alu_op`  out  2  ALU control class.
- `dmem_req`  out  1  data-memory request.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `bus_err`  out  1  one-cycle pulse on a MEM timeout.
- `halted`  out  1  the controller is in HALT.
- `state`  out  3  current state, for debug.

## Operation
- **States and encodings:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- **Opcode map:**
  - 0000 LD; 0001 ST.
  - 0010–1001 R-type ALU operations.
  - 1011 BEQ; 1100 BNE; 1101 JMP.
  - 1010, 1110 and 1111 are illegal.
- **FETCH:** `ir_we`=1 → DECODE.
- **DECODE:** latch `opcode` into `op_q` → EXEC. All later decoding uses `op_q` only.
- **Decoded controls** are held constant from EXEC until the instruction leaves:
  - LD/ST: `alu_src`=1, `alu_op`=10.
  - R-type: `reg_dst`=1, `alu_op`=00.
  - BEQ/BNE: `alu_op`=01.
  - JMP: `alu_op`=00.
- **EXEC transitions:**
  - BEQ, BNE, JMP: assert the matching `beq`/`bne`/`jump` together with `pc_we`=1 → FETCH.
  - LD/ST → MEM.
  - R-type → WB.
  - Illegal opcode: see Configuration.
- **MEM:**
  - `dmem_req`=1 throughout, plus `mem_read` (LD) or `mem_write` (ST).
  - An 8-bit wait counter, cleared on entry, increments each MEM cycle without `dmem_ack`.
  - On `dmem_ack`: LD → WB; ST asserts `pc_we`=1 → FETCH.
  - If the counter reaches MEM_TIMEOUT with no ack: `bus_err` pulses, then the Configuration rule applies.
- **WB:** `reg_write`=1 and `pc_we`=1; `mem_to_reg`=1 for LD → FETCH.
- **Strobe rules:**
  - `jump`, `beq`, `bne`, `reg_write`, `ir_we`, `pc_we` are 0 in every state not listed above.
  - `instr_done` = `pc_we`.
- **HALT:** all strobes 0 and `halted`=1. Only `rst` exits HALT.

## Timing
- **Reset:** `rst` high forces state=FETCH, `op_q`=0, wait counter=0 and every output 0, regardless of the cycle in progress. `rst` is sampled asynchronously.
- **First fetch:** `ir_we` rises in the first clock cycle after `rst` deasserts.
- **Latency (k = MEM wait cycles, minimum 0 extra):**
  - Branch/jump: 3 cycles.
  - R-type: 4 cycles.
  - ST: 4+k cycles.
  - LD: 5+k cycles.
- **Ack timing:**
  - `dmem_ack` is ignored outside MEM.
  - An ack in the first MEM cycle completes the access in one cycle.
  - An ack in the same cycle the counter reaches MEM_TIMEOUT counts as success, with no `bus_err`.
- **Handshake:** `dmem_req` deasserts in the cycle after the ack or timeout.
- **Instruction stability:** the instruction register is not rewritten until the next FETCH, so `opcode` stays stable through the whole instruction.

## Configuration
- **CTRL_TRAP_EN defined:** an illegal opcode in EXEC, or a MEM timeout, moves the controller to HALT with no `pc_we`. `halted` stays 1 until reset.
- **CTRL_TRAP_EN undefined:**
  - An illegal opcode is executed as a NOP: in EXEC, `pc_we`=1 with no branch strobes → FETCH.
  - A timeout abandons the instruction: `pc_we`=1 in the timeout cycle → FETCH, with no register write.
  - HALT is unreachable and `halted` is tied to 0.

## Test plan
- **Reset mid-MEM:** assert `rst` during an LD's MEM cycle → all outputs 0 immediately; after release, `ir_we`=1 on the next cycle and `state`=0.
- **R-type ADD (0010):** `state` sequence 0,1,2,4 → in WB, `reg_write`=1, `reg_dst`=1, `pc_we`=1, `alu_op`=00; `instr_done` pulses once.
- **LD with `dmem_ack` after 3 wait cycles:** MEM lasts 4 cycles with `dmem_req`=`mem_read`=1 → WB with `mem_to_reg`=1; 8 cycles total.
- **BEQ (1011):** in EXEC, `beq`=1, `pc_we`=1, `alu_op`=01; next state FETCH; 3 cycles total.
- **ST with `dmem_ack` never asserted, MEM_TIMEOUT=4:**
  - `bus_err` pulses in the 4th MEM cycle.
  - With CTRL_TRAP_EN: `halted`=1 and it persists.
  - Without: `pc_we`=1, then FETCH.
- **Opcode 1110:**
  - With CTRL_TRAP_EN: state=5 after EXEC.
  - Without: NOP retire, `instr_done`=1, 3 cycles.
